// File: rtl/alu_sliced_seq.sv
// Multi-cycle ALU: AND/OR/ADD/SLT over WIDTH bits, one SLICE-bit slice per clock, carry registered between slices.
// Latency N cycles (N+1 for SLT) from the start edge to done; start is ignored while busy.
module alu_sliced_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             binv,
    input  logic             cin,
    input  logic [1:0]       sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             co,
    output logic             ovf,
    output logic             zero
);
    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]       sel_q;
    logic             carry;
    logic [KW-1:0]    k;
    logic             sum_msb;

    logic [SLICE-1:0] a_s, b_s, s_out;
    logic [SLICE:0]   s_sum;
    logic [WIDTH-1:0] res_nxt;
    logic             c_msb, last, arith, slt_bit;

    // Slice datapath: one SLICE-bit adder/logic unit reused every RUN cycle.
    always_comb begin
        a_s     = a_q[k*SLICE +: SLICE];
        b_s     = b_q[k*SLICE +: SLICE];
        s_sum   = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, carry};
        c_msb   = a_s[SLICE-1] ^ b_s[SLICE-1] ^ s_sum[SLICE-1];
        last    = (k == K_LAST);
        arith   = sel_q[1];
        slt_bit = sum_msb ^ ovf;
        case (sel_q)
            2'b00:   s_out = a_s & b_s;
            2'b01:   s_out = a_s | b_s;
            default: s_out = s_sum[SLICE-1:0];
        endcase
        res_nxt = result;
        res_nxt[k*SLICE +: SLICE] = s_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = (sel_q == 2'b11) ? FIX : IDLE;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 2'b00;
            carry   <= 1'b0;
            k       <= '0;
            sum_msb <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            co      <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b ^ {WIDTH{binv}};
                        carry <= cin;
                        sel_q <= sel;
                        k     <= '0;
                    end
                end
                RUN: begin
                    result <= res_nxt;
                    carry  <= s_sum[SLICE];
                    if (!last) begin
                        k <= k + 1'b1;
                    end else begin
                        co      <= arith & s_sum[SLICE];
                        ovf     <= arith & (c_msb ^ s_sum[SLICE]);
                        sum_msb <= s_sum[SLICE-1];
                        // SLT finishes in FIX, where the sign/overflow correction is applied.
                        if (sel_q != 2'b11) begin
                            done <= 1'b1;
                            zero <= (res_nxt == '0);
                        end
                    end
                end
                FIX: begin
                    result <= {{(WIDTH-1){1'b0}}, slt_bit};
                    zero   <= ~slt_bit;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sliced_seq.sv
// Bench for alu_sliced_seq: transaction-level reference model with a per-cycle compare process,
// directed vectors with literal expectations, control corner cases and random traffic.
module tb_alu_sliced_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        binv = 1'b0, cin = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic        busy, done, co, ovf, zero;
    logic [31:0] result;

    logic        start2 = 1'b0;
    logic [23:0] a2 = '0, b2 = '0;
    logic        busy2, done2, co2, ovf2, zero2;
    logic [23:0] result2;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    alu_sliced_seq #(.WIDTH(32), .SLICE(16)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .binv(binv), .cin(cin), .sel(sel),
        .busy(busy), .done(done), .result(result), .co(co), .ovf(ovf), .zero(zero)
    );

    alu_sliced_seq #(.WIDTH(24), .SLICE(8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .binv(1'b0), .cin(1'b0), .sel(2'b10),
        .busy(busy2), .done(done2), .result(result2), .co(co2), .ovf(ovf2), .zero(zero2)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: whole-word arithmetic on the operands as the caller presents them.
    function automatic void alu_model(input logic [31:0] x, input logic [31:0] y, input logic bi,
                                      input logic ci, input logic [1:0] op,
                                      output logic [31:0] r, output logic c, output logic v);
        logic [31:0] yy;
        logic [32:0] s;
        yy = bi ? ~y : y;
        s  = {1'b0, x} + {1'b0, yy} + {32'd0, ci};
        c  = s[32];
        v  = (x[31] == yy[31]) && (s[31] != x[31]);
        case (op)
            2'b00:   begin r = x & yy; c = 1'b0; v = 1'b0; end
            2'b01:   begin r = x | yy; c = 1'b0; v = 1'b0; end
            2'b10:   r = s[31:0];
            default: r = {31'd0, s[31] ^ v};
        endcase
    endfunction

    int          m_cnt  = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_res  = '0, p_res = '0;
    logic        m_co = 1'b0, m_ovf = 1'b0, m_zero = 1'b0;
    logic        p_co = 1'b0, p_ovf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_done = 1'b0; m_res = '0; m_co = 1'b0; m_ovf = 1'b0; m_zero = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1'b1;
                    m_res  = p_res;
                    m_co   = p_co;
                    m_ovf  = p_ovf;
                    m_zero = (p_res == 32'd0);
                end
            end else if (start) begin
                alu_model(a, b, binv, cin, sel, p_res, p_co, p_ovf);
                m_cnt = (sel == 2'b11) ? 3 : 2;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_cnt > 0);
            check("done", done, m_done);
            if (m_cnt == 0) begin
                check("result", result, m_res);
                check("co", co, m_co);
                check("ovf", ovf, m_ovf);
                check("zero", zero, m_zero);
            end
        end
    end

    task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic xbi,
                          input logic xci, input logic [1:0] xs, input logic [31:0] er,
                          input logic eco, input logic eov, input logic ez, input int elat,
                          input bit poke);
        int cyc  = 0;
        int bcnt = 0;
        a = xa; b = xb; binv = xbi; cin = xci; sel = xs; start = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            start = poke && (cyc == 1);
            if (poke && cyc == 1) a = ~xa;
            if (busy) bcnt++;
        end while (!done && cyc < 20);
        check("lat", 64'(cyc), 64'(elat + 1));
        check("busy_cycles", 64'(bcnt), 64'(elat));
        check("d_result", result, er);
        check("d_co", co, eco);
        check("d_ovf", ovf, eov);
        check("d_zero", zero, ez);
    endtask

    initial begin
        int cyc;
        int dcnt;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {co, ovf, zero}, 3'b000);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        run_op(32'h0000FFFF, 32'h1, 0, 0, 2'b10, 32'h00010000, 0, 0, 0, 2, 0);
        run_op(32'd5, 32'd5, 1, 1, 2'b10, 32'h0, 1, 0, 1, 2, 0);
        run_op(32'h7FFFFFFF, 32'h1, 0, 0, 2'b10, 32'h80000000, 0, 1, 0, 2, 0);
        run_op(32'hFFFFFFFF, 32'h1, 1, 1, 2'b11, 32'h1, 1, 0, 0, 3, 0);
        run_op(32'h1, 32'hFFFFFFFF, 1, 1, 2'b11, 32'h0, 0, 0, 1, 3, 0);
        run_op(32'h80000000, 32'h1, 1, 1, 2'b11, 32'h1, 1, 1, 0, 3, 0);
        run_op(32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 2'b00, 32'hF000F000, 0, 0, 0, 2, 0);
        run_op(32'hF0F0F0F0, 32'hFF00FF00, 1, 0, 2'b01, 32'hF0FFF0FF, 0, 0, 0, 2, 0);
        // Second start pulses while busy and changes a; the result must be 10+20.
        run_op(32'd10, 32'd20, 0, 0, 2'b10, 32'd30, 0, 0, 0, 2, 1);
        // Started from the done cycle of the previous op: back-to-back acceptance.
        run_op(32'd100, 32'd23, 0, 0, 2'b10, 32'd123, 0, 0, 0, 2, 0);

        // Abort mid-operation with reset after E1.
        a = 32'h12345678; b = 32'h1; binv = 0; cin = 0; sel = 2'b10; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_result", result, 32'd0);
        check("abort_flags", {co, ovf, zero}, 3'b000);
        @(negedge clk); rst = 1'b0;
        dcnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'd0);

        // 24-bit / 8-bit slice instance: three slices.
        a2 = 24'h00FFFF; b2 = 24'h000001; start2 = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            start2 = 1'b0;
        end while (!done2 && cyc < 20);
        check("w24_lat", 64'(cyc), 64'd4);
        check("w24_result", result2, 24'h010000);
        check("w24_flags", {co2, ovf2, zero2}, 3'b000);

        // Random traffic: start requests at random, including while busy and on done cycles.
        repeat (3000) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) != 0);
            sel   = 2'($urandom_range(0, 3));
            binv  = 1'($urandom_range(0, 1));
            cin   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       begin a = $urandom; b = $urandom; end
                1:       begin a = 32'h7FFFFFFF ^ 32'($urandom_range(0, 3)); b = 32'($urandom_range(0, 3)); end
                2:       begin a = 32'h80000000; b = $urandom; end
                default: begin a = $urandom; b = a; end
            endcase
        end
        start = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
